game_seq: RTL and testbench
===========================

GAME_SEQ -- requirements
Module: game_seq

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 Parameter CD_FRAMES, default 60, frames per countdown step.
REQ-003 Parameter CLEAR_FRAMES, default 120, frames held in LEVEL_CLEAR.
REQ-004 Parameter OVER_FRAMES, default 180, frames held in GAME_OVER.
REQ-005 Parameter MAX_LEVEL, default 9, level saturation value.
REQ-006 Parameter SHOT_CD, default 8, frames between granted shots.
REQ-007 clk  in  1  100 MHz system clock; the only clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 move  in  1  one-cycle frame tick at start of vertical blanking.
REQ-010 start  in  1  raw start button level.
REQ-011 shoot  in  1  raw fire button level.
REQ-012 broken  in  12  per-enemy destroyed flags.
REQ-013 player_hit  in  1  one-cycle pulse, player struck.
REQ-014 state  out  3  0 ATTRACT, 1 COUNTDOWN, 2 PLAY, 3 LEVEL_CLEAR, 4 GAME_OVER.
REQ-015 round_rst  out  1  one-cycle pulse re-initialising sprites.
REQ-016 play_en  out  1  high only in PLAY.
REQ-017 level  out  4  current level, 1..MAX_LEVEL.
REQ-018 lives  out  2  remaining lives.
REQ-019 cd_digit  out  2  countdown digit 3..1, 0 outside COUNTDOWN.
REQ-020 shot_grant  out  1  one-cycle pulse authorising one bullet.

Function
REQ-021 All outputs registered; frame counter advances only on cycles with move=1.
REQ-022 start and shoot edge-detected via one register stage; rising edge = current high, previous low.
REQ-023 ATTRACT: on start edge -> COUNTDOWN, level=1, lives=LIVES_INIT, round_rst pulse same cycle as transition, frame counter cleared.
REQ-024 COUNTDOWN: cd_digit starts 3, decrements every CD_FRAMES moves; on move completing the step with cd_digit=1 -> PLAY, cd_digit=0.
REQ-025 PLAY: all 12 broken bits high -> LEVEL_CLEAR, counter cleared.
REQ-026 PLAY: player_hit with lives>1 -> lives decrements, round_rst pulse, -> COUNTDOWN (level unchanged).
REQ-027 PLAY: player_hit with lives=1 -> lives=0, -> GAME_OVER.
REQ-028 Simultaneous all-broken and player_hit in same cycle: all-broken wins; lives unchanged.
REQ-029 LEVEL_CLEAR: after CLEAR_FRAMES moves -> COUNTDOWN, level+1 saturating at MAX_LEVEL, round_rst pulse.
REQ-030 GAME_OVER: after OVER_FRAMES moves, or start edge if counter >= 30, -> ATTRACT; level and lives hold until next game.
REQ-031 player_hit and broken ignored outside PLAY.
REQ-032 Shot arbitration: in PLAY, shoot edge with cooldown=0 -> shot_grant pulse one cycle, cooldown=SHOT_CD.
REQ-033 Cooldown decrements on move, floors at 0; shoot edge while cooldown>0 discarded (not queued).
REQ-034 shot_grant never asserted outside PLAY; cooldown cleared on any exit from PLAY.
REQ-035 round_rst pulses exactly one clk per triggering transition; never two consecutive cycles.
REQ-036 Frame counter width >= 8 bits; no wrap within any state's dwell.

Reset
REQ-037 rst high at clock edge: state=ATTRACT, level=1, lives=0, cd_digit=0, play_en=0, round_rst=0, shot_grant=0, counters and edge registers 0.
REQ-038 rst mid-PLAY aborts immediately to ATTRACT with no round_rst pulse; held start after rst release does not start a game until released and re-pressed.

Verification
REQ-039 rst; start edge -> state 1, round_rst one pulse, cd_digit 3; 180 moves -> state 2, cd_digit 0, play_en 1.
REQ-040 PLAY, broken=12'hFFF -> state 3; 120 moves -> state 1, level 2, round_rst pulse; repeat to level 9 -> stays 9.
REQ-041 PLAY, lives 3, three player_hit (countdowns between) -> lives 2, 1, then state 4; 180 moves -> state 0.
REQ-042 PLAY, shoot pulsed every frame for 20 frames -> shot_grant on frames 0, 8, 16 only (3 pulses).
REQ-043 Same cycle broken=12'hFFF and player_hit -> state 3, lives unchanged.
REQ-044 rst asserted during COUNTDOWN with start held -> state 0 next cycle; no game start until start low then high.

Source files
------------

// File: rtl/game_seq.sv
`default_nettype none
// ============================================================================
//  Module      : game_seq
//  Description : Game flow sequencer (attract, countdown, play, level clear,
//                game over) with frame-based timing and shot arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_seq #(
    parameter int LIVES_INIT   = 3,
    parameter int CD_FRAMES    = 60,
    parameter int CLEAR_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int MAX_LEVEL    = 9,
    parameter int SHOT_CD      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move,
    input  logic        start,
    input  logic        shoot,
    input  logic [11:0] broken,
    input  logic        player_hit,
    output logic [2:0]  state,
    output logic        round_rst,
    output logic        play_en,
    output logic [3:0]  level,
    output logic [1:0]  lives,
    output logic [1:0]  cd_digit,
    output logic        shot_grant
);

    localparam logic [2:0] c_ST_ATTRACT = 3'd0;
    localparam logic [2:0] c_ST_COUNT   = 3'd1;
    localparam logic [2:0] c_ST_PLAY    = 3'd2;
    localparam logic [2:0] c_ST_CLEAR   = 3'd3;
    localparam logic [2:0] c_ST_OVER    = 3'd4;

    localparam int c_MAXF_A = (CD_FRAMES > CLEAR_FRAMES) ? CD_FRAMES : CLEAR_FRAMES;
    localparam int c_MAXF   = (c_MAXF_A > OVER_FRAMES) ? c_MAXF_A : OVER_FRAMES;
    localparam int c_FW     = ($clog2(c_MAXF + 1) > 8) ? $clog2(c_MAXF + 1) : 8;
    localparam int c_CW     = ($clog2(SHOT_CD + 1) > 1) ? $clog2(SHOT_CD + 1) : 1;

    localparam logic [c_FW-1:0] c_CD_LAST    = c_FW'(CD_FRAMES - 1);
    localparam logic [c_FW-1:0] c_CLEAR_LAST = c_FW'(CLEAR_FRAMES - 1);
    localparam logic [c_FW-1:0] c_OVER_LAST  = c_FW'(OVER_FRAMES - 1);
    localparam logic [c_FW-1:0] c_OVER_SKIP  = c_FW'(30);
    localparam logic [c_CW-1:0] c_SHOT       = c_CW'(SHOT_CD);
    localparam logic [3:0]      c_MAXLVL     = 4'(MAX_LEVEL);
    localparam logic [1:0]      c_LIVES      = 2'(LIVES_INIT);

    logic [2:0]      r_state;
    logic            r_round_rst;
    logic            r_play_en;
    logic [3:0]      r_level;
    logic [1:0]      r_lives;
    logic [1:0]      r_cd;
    logic            r_shot;
    logic [c_FW-1:0] r_frames;
    logic [c_CW-1:0] r_cool;
    logic            r_start_d;
    logic            r_shoot_d;
    logic            r_start_armed;

    logic w_start_edge;
    logic w_shoot_edge;
    logic w_all_broken;

    // A start held through reset must be released once before it can count.
    assign w_start_edge = start & ~r_start_d & r_start_armed;
    assign w_shoot_edge = shoot & ~r_shoot_d;
    assign w_all_broken = &broken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_ATTRACT;
            r_round_rst   <= 1'b0;
            r_play_en     <= 1'b0;
            r_level       <= 4'd1;
            r_lives       <= 2'd0;
            r_cd          <= 2'd0;
            r_shot        <= 1'b0;
            r_frames      <= '0;
            r_cool        <= '0;
            r_start_d     <= 1'b0;
            r_shoot_d     <= 1'b0;
            r_start_armed <= 1'b0;
        end else begin
            r_start_d     <= start;
            r_shoot_d     <= shoot;
            r_start_armed <= r_start_armed | ~start;
            r_round_rst   <= 1'b0;
            r_shot        <= 1'b0;
            if (move) begin
                r_frames <= r_frames + 1'b1;
            end

            case (r_state)
                c_ST_ATTRACT: begin
                    r_frames <= '0;
                    if (w_start_edge) begin
                        r_state     <= c_ST_COUNT;
                        r_level     <= 4'd1;
                        r_lives     <= c_LIVES;
                        r_cd        <= 2'd3;
                        r_round_rst <= 1'b1;
                    end
                end

                c_ST_COUNT: begin
                    if (move && r_frames == c_CD_LAST) begin
                        r_frames <= '0;
                        if (r_cd == 2'd1) begin
                            r_state   <= c_ST_PLAY;
                            r_cd      <= 2'd0;
                            r_play_en <= 1'b1;
                            r_cool    <= '0;
                        end else begin
                            r_cd <= r_cd - 2'd1;
                        end
                    end
                end

                c_ST_PLAY: begin
                    if (w_all_broken || player_hit) begin
                        r_frames  <= '0;
                        r_cool    <= '0;
                        r_play_en <= 1'b0;
                        if (w_all_broken) begin
                            r_state <= c_ST_CLEAR;
                        end else if (r_lives > 2'd1) begin
                            r_state     <= c_ST_COUNT;
                            r_lives     <= r_lives - 2'd1;
                            r_cd        <= 2'd3;
                            r_round_rst <= 1'b1;
                        end else begin
                            r_state <= c_ST_OVER;
                            r_lives <= 2'd0;
                        end
                    end else if (w_shoot_edge && r_cool == '0) begin
                        r_shot <= 1'b1;
                        r_cool <= c_SHOT;
                    end else if (move && r_cool != '0) begin
                        r_cool <= r_cool - 1'b1;
                    end
                end

                c_ST_CLEAR: begin
                    if (move && r_frames == c_CLEAR_LAST) begin
                        r_state     <= c_ST_COUNT;
                        r_frames    <= '0;
                        r_cd        <= 2'd3;
                        r_round_rst <= 1'b1;
                        if (r_level < c_MAXLVL) begin
                            r_level <= r_level + 4'd1;
                        end
                    end
                end

                c_ST_OVER: begin
                    if ((move && r_frames == c_OVER_LAST) ||
                        (w_start_edge && r_frames >= c_OVER_SKIP)) begin
                        r_state  <= c_ST_ATTRACT;
                        r_frames <= '0;
                    end
                end

                default: begin
                    r_state   <= c_ST_ATTRACT;
                    r_frames  <= '0;
                    r_play_en <= 1'b0;
                    r_cd      <= 2'd0;
                    r_cool    <= '0;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign round_rst  = r_round_rst;
    assign play_en    = r_play_en;
    assign level      = r_level;
    assign lives      = r_lives;
    assign cd_digit   = r_cd;
    assign shot_grant = r_shot;

endmodule
`default_nettype wire

// File: tb/tb_game_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_seq
//  Description : Directed self-checking bench for game_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        move = 1'b0;
    logic        start = 1'b0;
    logic        shoot = 1'b0;
    logic [11:0] broken = 12'h000;
    logic        player_hit = 1'b0;
    logic [2:0]  state;
    logic        round_rst;
    logic        play_en;
    logic [3:0]  level;
    logic [1:0]  lives;
    logic [1:0]  cd_digit;
    logic        shot_grant;

    int r_total = 0;
    int r_bad   = 0;
    int r_grants;

    game_seq dut (
        .clk        (clk),
        .rst        (rst),
        .move       (move),
        .start      (start),
        .shoot      (shoot),
        .broken     (broken),
        .player_hit (player_hit),
        .state      (state),
        .round_rst  (round_rst),
        .play_en    (play_en),
        .level      (level),
        .lives      (lives),
        .cd_digit   (cd_digit),
        .shot_grant (shot_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        r_total++;
        if (got != exp) begin
            r_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic moves(input int n);
        move = 1'b1;
        repeat (n) step();
        move = 1'b0;
    endtask

    task automatic clear_level();
        broken = 12'hFFF;
        step();
        broken = 12'h000;
        moves(120);
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_level", level, 1);
        chk("rst_lives", lives, 0);
        chk("rst_cd", cd_digit, 0);
        chk("rst_play_en", play_en, 0);
        chk("rst_round_rst", round_rst, 0);
        rst = 1'b0;
        step();

        // game start
        start = 1'b1;
        step();
        chk("start_state", state, 1);
        chk("start_round_rst", round_rst, 1);
        chk("start_cd", cd_digit, 3);
        chk("start_lives", lives, 3);
        start = 1'b0;
        step();
        chk("start_round_rst_once", round_rst, 0);

        // countdown
        moves(60);
        chk("cd_step1", cd_digit, 2);
        moves(119);
        chk("cd_last_state", state, 1);
        chk("cd_last_digit", cd_digit, 1);
        moves(1);
        chk("play_state", state, 2);
        chk("play_cd", cd_digit, 0);
        chk("play_en", play_en, 1);

        // partial break does nothing
        broken = 12'h7FF;
        step();
        broken = 12'h000;
        chk("partial_broken", state, 2);

        // shot arbitration: one shoot edge per frame
        r_grants = 0;
        for (int f = 0; f < 20; f++) begin
            shoot = 1'b1;
            step();
            chk($sformatf("shot_f%0d", f), shot_grant, (f % 8 == 0) ? 1 : 0);
            if (shot_grant) r_grants++;
            shoot = 1'b0;
            step();
            chk("shot_pulse_width", shot_grant, 0);
            moves(1);
        end
        chk("shot_count", r_grants, 3);

        // simultaneous all-broken and hit
        broken = 12'hFFF;
        player_hit = 1'b1;
        step();
        broken = 12'h000;
        player_hit = 1'b0;
        chk("both_state", state, 3);
        chk("both_lives", lives, 3);
        chk("both_play_en", play_en, 0);
        chk("clear_no_grant", shot_grant, 0);
        moves(119);
        chk("clear_hold", state, 3);
        moves(1);
        chk("clear_state", state, 1);
        chk("clear_level", level, 2);
        chk("clear_round_rst", round_rst, 1);
        step();
        chk("clear_round_rst_once", round_rst, 0);

        // level progression to saturation
        for (int l = 3; l <= 10; l++) begin
            moves(180);
            clear_level();
            chk($sformatf("level_%0d", l), level, (l > 9) ? 9 : l);
        end

        // lives
        moves(180);
        chk("hit_play", state, 2);
        player_hit = 1'b1;
        step();
        player_hit = 1'b0;
        chk("hit1_lives", lives, 2);
        chk("hit1_state", state, 1);
        chk("hit1_round_rst", round_rst, 1);
        chk("hit1_level", level, 9);
        moves(180);
        player_hit = 1'b1;
        step();
        player_hit = 1'b0;
        chk("hit2_lives", lives, 1);
        moves(180);
        player_hit = 1'b1;
        step();
        player_hit = 1'b0;
        chk("hit3_lives", lives, 0);
        chk("hit3_state", state, 4);
        chk("hit3_round_rst", round_rst, 0);

        // early start during game over is ignored
        moves(5);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("over_early_start", state, 4);
        moves(174);
        chk("over_hold", state, 4);
        moves(1);
        chk("over_exit", state, 0);
        chk("over_level_hold", level, 9);
        chk("over_lives_hold", lives, 0);

        // hits and breaks ignored in attract
        broken = 12'hFFF;
        player_hit = 1'b1;
        step();
        broken = 12'h000;
        player_hit = 1'b0;
        chk("attract_ignore", state, 0);

        // reset with start held
        start = 1'b1;
        step();
        chk("restart_state", state, 1);
        chk("restart_level", level, 1);
        rst = 1'b1;
        step();
        chk("rst_cd_state", state, 0);
        chk("rst_cd_round_rst", round_rst, 0);
        rst = 1'b0;
        step();
        step();
        chk("held_start_state", state, 0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("repress_state", state, 1);
        chk("repress_round_rst", round_rst, 1);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
